// File: rtl/divide_pkg.sv
// Shared definitions for the restoring divider: controller state encodings,
// the default operand width and the iteration-counter width helper.
package divide_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        SUBTRACT = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Bits needed to count WIDTH iterations (0 .. WIDTH-1).
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle between the processor FSM (master) and the divider
// (slave). Handshake: the master raises start with operands valid; the divider
// accepts it only while idle, and a one-cycle done marks the results valid.
// state is a read-only observation of the controller FSM.
interface restoring_divider_if import divide_pkg::*; #(parameter int WIDTH = DEF_WIDTH);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    state_t           state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, state
    );

endinterface

// File: rtl/divide_controller.sv
// FSM and iteration counter for the restoring divider. One SHIFT/SUBTRACT pair
// per quotient bit; a zero divisor skips straight to DONE.
module divide_controller import divide_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   start,
    input  logic   div_zero,
    input  logic   diff_neg,
    output logic   load,
    output logic   shift,
    output logic   sub_en,
    output logic   finish,
    output logic   busy,
    output logic   done,
    output state_t state
);

    localparam int CW = count_width(WIDTH);

    state_t        next_state;
    logic [CW-1:0] count;
    logic          last;

    assign last = (count == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Iteration counter: cleared on an accepted start, advanced after each
    // non-final subtract step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         count <= '0;
        else if (load && !div_zero)           count <= '0;
        else if (state == SUBTRACT && !last)  count <= count + CW'(1);
    end

    // Next-state and datapath control decode.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        sub_en     = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = div_zero ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                shift      = 1'b1;
                next_state = SUBTRACT;
            end
            SUBTRACT: begin
                busy   = 1'b1;
                sub_en = ~diff_neg;
                if (last) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end else begin
                    next_state = SHIFT;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring (shift-subtract) divider: WIDTH iterations of two
// cycles each. Define DIV_SIGNED_EN for two's-complement operands (magnitudes
// are divided, then quotient/remainder signs are applied on the final step).
module restoring_divider import divide_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    restoring_divider_if.slave bus
);

    logic             load;
    logic             shift;
    logic             sub_en;
    logic             finish;
    logic             div_zero;
    logic             diff_neg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    divide_controller #(.WIDTH(WIDTH)) u_ctrl (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (bus.start),
        .div_zero (div_zero),
        .diff_neg (diff_neg),
        .load     (load),
        .shift    (shift),
        .sub_en   (sub_en),
        .finish   (finish),
        .busy     (bus.busy),
        .done     (bus.done),
        .state    (bus.state)
    );

    assign div_zero = (bus.divisor == '0);
    assign diff     = a_reg - m_reg;
    assign diff_neg = diff[WIDTH];

    // Final-step values: the last quotient bit and the restored remainder are
    // folded in here so results register on the same edge as the last subtract.
    assign q_res = {q_reg[WIDTH-1:1], ~diff_neg};
    assign r_res = diff_neg ? a_reg[WIDTH-1:0] : diff[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    logic sign_q;
    logic sign_r;

    assign dividend_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign divisor_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign q_out        = sign_q ? -q_res : q_res;
    assign r_out        = sign_r ? -r_res : r_res;

    // Result signs captured with the operands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else if (load && !div_zero) begin
            sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r <= bus.dividend[WIDTH-1];
        end
    end
`else
    assign dividend_mag = bus.dividend;
    assign divisor_mag  = bus.divisor;
    assign q_out        = q_res;
    assign r_out        = r_res;
`endif

    // Partial remainder, dividend/quotient shifter and divisor registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
        end else if (load && !div_zero) begin
            a_reg <= '0;
            q_reg <= dividend_mag;
            m_reg <= {1'b0, divisor_mag};
        end else if (shift) begin
            {a_reg, q_reg} <= {a_reg[WIDTH-1:0], q_reg, 1'b0};
        end else if (sub_en) begin
            a_reg    <= diff;
            q_reg[0] <= 1'b1;
        end
    end

    // Result registers, held until the next accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (load && div_zero) begin
            bus.quotient    <= '1;
            bus.remainder   <= bus.dividend;
            bus.div_by_zero <= 1'b1;
        end else if (load) begin
            bus.div_by_zero <= 1'b0;
        end else if (finish) begin
            bus.quotient  <= q_out;
            bus.remainder <= r_out;
        end
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned shift-subtract (restoring) divider; the inverse operation of the team's shift-add multiplier.
- Contains the FSM controller plus the datapath: dividend/quotient shift register, divisor register, partial-remainder register and bit counter.
- Sits beside the multiplier in the execute stage of the multi-cycle datapath. The processor FSM starts it with a start pulse and waits for done.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 2).

Ports:
clock  input  1  FSM/datapath clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
dividend  input  WIDTH  numerator, captured on the accepted start edge.
divisor  input  WIDTH  denominator, captured on the accepted start edge.
busy  output  1  high in SHIFT and SUBTRACT.
done  output  1  single-cycle pulse; results are valid.
quotient  output  WIDTH  result; held until the next accepted start.
remainder  output  WIDTH  result; held until the next accepted start.
div_by_zero  output  1  set with done when divisor==0; held like the results.

Behaviour:
- Interface: one clock named clock; reset_n is asynchronous and active-low.
- Reset, at any time including mid-operation:
  - state=IDLE, count=0.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Any in-flight operation is abandoned.
- Internal registers:
  - A: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, dividend shifting into quotient.
  - M: WIDTH+1 bits, zero-extended divisor.
  - count: clog2(WIDTH) bits.
- States: IDLE, SHIFT, SUBTRACT, DONE. Encoded as 2-bit localparams.
- IDLE:
  - If start=1 and divisor!=0: Q<=dividend, M<=divisor, A<=0, count<=0, div_by_zero<=0; go to SHIFT.
  - If start=1 and divisor==0: quotient<=all ones, remainder<=dividend, div_by_zero<=1; go to DONE. No iterations are performed.
- SHIFT: {A,Q} <= {A,Q}<<1 (Q[0] becomes 0); go to SUBTRACT.
- SUBTRACT: diff=A-M, WIDTH+1 bits.
  - diff MSB=0: A<=diff, Q[0]<=1.
  - Otherwise: A unchanged, Q[0]<=0.
  - If count==WIDTH-1: quotient<=Q (with the new bit), remainder<=A[WIDTH-1:0] (restored/updated value); go to DONE.
  - Otherwise: count<=count+1; go to SHIFT.
- DONE: done=1 for exactly this cycle; go to IDLE unconditionally.
- Latency:
  - Normal case: done is high in the cycle after the 2*WIDTH-th edge following the start-sampling edge. For WIDTH=8 this is 16 edges.
  - Divide-by-zero: done is high after 1 edge.
- Throughput: a new start can be accepted the cycle after done. Worst-case start-to-start interval is 2*WIDTH+2 cycles.
- start while busy or in DONE is ignored. It is not queued.
- Operand inputs may change freely after the accepting edge.
- busy and done are never high in the same cycle.
- Arithmetic identity: dividend == quotient*divisor + remainder, and remainder < divisor, whenever divisor!=0.

Optional Feature:
DIV_SIGNED_EN
- Defined: operands are two's complement.
  - IDLE captures magnitudes |dividend| and |divisor|, and registers sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - On the SUBTRACT->DONE transition, quotient and remainder are negated per sign_q and sign_r before being registered. There is no extra latency.
  - Most-negative / -1 wraps: for WIDTH=8, -128/-1 gives quotient=0x80, remainder=0.
  - Divide-by-zero: quotient=all ones (-1), remainder=dividend.
- Undefined: unsigned only; no sign registers are synthesised.

Decomposition:
- Shared package divide_pkg holds:
  - state encodings IDLE/SHIFT/SUBTRACT/DONE;
  - the default WIDTH;
  - the count-width function.
- One sub-module, divide_controller:
  - contains the FSM and counter;
  - takes inputs start, div_zero and diff_neg;
  - drives the control outputs load, shift, sub_en, finish, busy and done.
- The top level holds the datapath registers and the subtractor.

Test Plan:
- 100/7, WIDTH=8 -> quotient=14, remainder=2, div_by_zero=0; done exactly 16 edges after start; busy high for 16 cycles.
- 5/9 -> quotient=0, remainder=5. 255/1 -> quotient=255, remainder=0. 255/255 -> quotient=1, remainder=0.
- 42/0 -> done after 1 edge, div_by_zero=1, quotient=0xFF, remainder=42. A following 42/6 clears div_by_zero and gives quotient=7.
- start pulses and operand changes mid-operation during 200/3 -> ignored; result is quotient=66, remainder=2. Then reset_n=0 mid-run of 77/5 -> all outputs 0, state IDLE; the next 77/5 gives quotient=15, remainder=2.
- With DIV_SIGNED_EN, -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2). 100/-7 -> quotient=-14, remainder=2. -128/-1 -> quotient=0x80, remainder=0.
- Random self-checking: 1000 operand pairs against a reference model; check the dividend=q*d+r identity and the latency every time.
